// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute/writeback controller for the 8-bit CPU datapath
module cpu_sequencer #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_data,
    output logic [2:0]      rf_raddr_a,
    output logic [2:0]      rf_raddr_b,
    input  logic [7:0]      rf_rdata_a,
    input  logic [7:0]      rf_rdata_b,
    output logic [1:0]      alu_op,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    input  logic [7:0]      alu_y,
    output logic            rf_we,
    output logic [2:0]      rf_waddr,
    output logic [7:0]      rf_wdata,
    output logic            flag_zero,
    output logic            halted,
    output logic [2:0]      state,
    output logic [PC_W-1:0] pc
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_WB2    = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_ir;
    logic [7:0]      r_opa;
    logic [7:0]      r_opb;
    logic [7:0]      r_res;
    logic            r_zero;
    logic [1:0]      w_op;
    logic [2:0]      w_sub;
    logic            w_single;
    logic            w_halt;
    logic            w_swap;
    logic            w_fire;

    assign w_op     = r_ir[7:6];
    assign w_sub    = r_ir[5:3];
    assign w_single = (w_op == 2'd0) && (w_sub == 3'd1 || w_sub == 3'd2 || w_sub == 3'd3);
    assign w_halt   = (w_op == 2'd0) && (w_sub == 3'd7);
    assign w_swap   = (w_op == 2'd3);
    assign w_fire   = imem_req && imem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_FETCH;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = w_fire ? S_DECODE : S_FETCH;
            S_DECODE: w_next = w_halt ? S_HALT : (w_op != 2'd0 || w_single) ? S_READ : S_FETCH;
            S_READ:   w_next = w_swap ? S_WB : S_EXEC;
            S_EXEC:   w_next = S_WB;
            S_WB:     w_next = w_swap ? S_WB2 : S_FETCH;
            S_WB2:    w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    // Single-operand ops work on B; two-operand ops write A, and SWAP's second beat writes B.
    always_comb begin
        imem_req = (r_state == S_FETCH) && run && !rst;
        rf_we    = (r_state == S_WB || r_state == S_WB2) && !rst;
        rf_waddr = (r_state == S_WB2 || w_op == 2'd0) ? r_ir[2:0] : r_ir[5:3];
        rf_wdata = (r_state == S_WB2) ? r_opa : w_swap ? r_opb : r_res;
        alu_op   = (w_op == 2'd1) ? 2'd0 : (w_op == 2'd2) ? 2'd1 :
                   (w_sub == 3'd1) ? 2'd0 : (w_sub == 3'd2) ? 2'd1 : 2'd3;
        alu_a    = (w_op == 2'd0) ? r_opb : r_opa;
        alu_b    = (w_op == 2'd0) ? ((w_sub == 3'd3) ? 8'd0 : 8'd1) : r_opb;
        halted   = (r_state == S_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc   <= '0;
            r_ir   <= 8'd0;
            r_opa  <= 8'd0;
            r_opb  <= 8'd0;
            r_res  <= 8'd0;
            r_zero <= 1'b0;
        end else begin
            if (r_state == S_FETCH && w_fire) begin
                r_ir <= imem_data;
                r_pc <= r_pc + PC_W'(1);
            end
            if (r_state == S_READ) begin
                r_opa <= rf_rdata_a;
                r_opb <= rf_rdata_b;
            end
            if (r_state == S_EXEC) begin
                r_res  <= alu_y;
                r_zero <= (alu_y == 8'd0);
            end
        end
    end

    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign state      = r_state;
    assign flag_zero  = r_zero;
    assign rf_raddr_a = r_ir[5:3];
    assign rf_raddr_b = r_ir[2:0];
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed vector bench with register-file, ALU and instruction-memory models
module tb_cpu_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [2:0] rf_raddr_a, rf_raddr_b;
    logic [7:0] rf_rdata_a, rf_rdata_b;
    logic [1:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_y;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       flag_zero, halted;
    logic [2:0] state;
    logic [7:0] pc;

    cpu_sequencer #(.PC_W(8)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flag_zero(flag_zero), .halted(halted), .state(state), .pc(pc)
    );

    always #5 clk = ~clk;

    logic [7:0] rf [8];
    logic       pl_en = 1'b0;
    logic [2:0] pl_a0, pl_a1;
    logic [7:0] pl_d0, pl_d1;
    always @(posedge clk) begin
        if (pl_en) begin
            rf[pl_a0] <= pl_d0;
            rf[pl_a1] <= pl_d1;
        end
        if (rf_we) rf[rf_waddr] <= rf_wdata;
    end
    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];

    assign alu_y = (alu_op == 2'd0) ? alu_a + alu_b : (alu_op == 2'd1) ? alu_a - alu_b :
                   (alu_op == 2'd2) ? alu_a : alu_b;

    logic [7:0] imem [256];
    logic [7:0] wcnt = 8'd0;
    int         dly = 0;
    logic       force_ack = 1'b0;
    always @(posedge clk) wcnt <= (imem_req && !imem_ack) ? wcnt + 8'd1 : 8'd0;
    assign imem_ack  = force_ack || (imem_req && int'(wcnt) >= dly);
    assign imem_data = imem[imem_addr];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [2:0] a0, input logic [7:0] d0, input logic [2:0] a1, input logic [7:0] d1);
        pl_a0 = a0; pl_d0 = d0; pl_a1 = a1; pl_d1 = d1; pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    typedef struct {
        logic [7:0] ins;
        logic [2:0] ra, rb;
        logic [7:0] va, vb, ea, eb;
        logic       ez;
        int         cyc, nwe, first;
    } vec_t;

    vec_t v[10];

    initial begin
        int cyc, nwe, first, k;
        logic [7:0] exp_pc;
        // instr, regA, regB, preA, preB, expA, expB, zero, cycles, writes, first-write cycle
        v[0] = '{8'h4A, 3'd1, 3'd2, 8'h03, 8'h04, 8'h07, 8'h04, 1'b0, 5, 1, 5};
        v[1] = '{8'h9B, 3'd3, 3'd3, 8'h55, 8'h55, 8'h00, 8'h00, 1'b1, 5, 1, 5};
        v[2] = '{8'h00, 3'd0, 3'd0, 8'h11, 8'h11, 8'h11, 8'h11, 1'b1, 2, 0, 0};
        v[3] = '{8'hC7, 3'd0, 3'd7, 8'h11, 8'h22, 8'h22, 8'h11, 1'b1, 5, 2, 4};
        v[4] = '{8'h0D, 3'd5, 3'd5, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, 5, 1, 5};
        v[5] = '{8'h15, 3'd5, 3'd5, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b0, 5, 1, 5};
        v[6] = '{8'h1E, 3'd6, 3'd6, 8'h5A, 8'h5A, 8'h00, 8'h00, 1'b1, 5, 1, 5};
        v[7] = '{8'h50, 3'd2, 3'd0, 8'hF0, 8'h10, 8'h00, 8'h10, 1'b1, 5, 1, 5};
        v[8] = '{8'h22, 3'd2, 3'd2, 8'h33, 8'h33, 8'h33, 8'h33, 1'b1, 2, 0, 0};
        v[9] = '{8'h8A, 3'd1, 3'd2, 8'h05, 8'h07, 8'hFE, 8'h07, 1'b0, 5, 1, 5};
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;

        rst = 1'b1; run = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_zero", 32'(flag_zero), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        run = 1'b0; rst = 1'b0;
        @(negedge clk);
        exp_pc = 8'd0;

        for (int i = 0; i < 10; i++) begin
            preload(v[i].ra, v[i].va, v[i].rb, v[i].vb);
            imem[exp_pc] = v[i].ins;
            run = 1'b1; cyc = 0; nwe = 0; first = 0;
            do begin
                if (rf_we) begin
                    nwe++;
                    if (first == 0) first = cyc + 1;
                end
                @(negedge clk);
                cyc++;
                run = 1'b0;
            end while (state != 3'd0 && cyc < 40);
            exp_pc = exp_pc + 8'd1;
            chk($sformatf("v%0d_cycles", i), cyc, v[i].cyc);
            chk($sformatf("v%0d_writes", i), nwe, v[i].nwe);
            chk($sformatf("v%0d_first_we", i), first, v[i].first);
            chk($sformatf("v%0d_rA", i), 32'(rf[v[i].ra]), 32'(v[i].ea));
            chk($sformatf("v%0d_rB", i), 32'(rf[v[i].rb]), 32'(v[i].eb));
            chk($sformatf("v%0d_zero", i), 32'(flag_zero), 32'(v[i].ez));
            chk($sformatf("v%0d_pc", i), 32'(pc), 32'(exp_pc));
        end

        // Reset arriving in the WB cycle of ADD r1,r2 must suppress the write.
        preload(3'd1, 8'h01, 3'd2, 8'h02);
        imem[exp_pc] = 8'h4A;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0; k = 0;
        while (state != 3'd4 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("abort_in_wb", 32'(state), 32'd4);
        chk("abort_wb_we", 32'(rf_we), 32'd1);
        chk("abort_wb_waddr", 32'(rf_waddr), 32'd1);
        chk("abort_wb_wdata", 32'(rf_wdata), 32'd3);
        rst = 1'b1;
        #1;
        chk("abort_we", 32'(rf_we), 32'd0);
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_pc", 32'(pc), 32'd0);
        chk("abort_zero", 32'(flag_zero), 32'd0);
        chk("abort_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("abort_r1_kept", 32'(rf[1]), 32'h01);
        rst = 1'b0;
        @(negedge clk);

        // Walk NOPs up to pc=0xFF, then fetch across the wrap with three wait cycles.
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        run = 1'b1; k = 0;
        while (!(state == 3'd1 && pc == 8'hFF) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("wrap_reach", 32'(pc), 32'hFF);
        dly = 3;
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            chk($sformatf("wait%0d_req", w), 32'(imem_req), 32'd1);
            chk($sformatf("wait%0d_addr", w), 32'(imem_addr), 32'hFF);
            chk($sformatf("wait%0d_ack", w), 32'(imem_ack), 32'd0);
        end
        @(negedge clk);
        chk("wait_ack", 32'(imem_ack), 32'd1);
        @(negedge clk);
        chk("wrap_pc", 32'(pc), 32'd0);
        chk("wrap_decode", 32'(state), 32'd1);
        run = 1'b0; dly = 0;
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            chk($sformatf("idle%0d_req", w), 32'(imem_req), 32'd0);
            chk($sformatf("idle%0d_pc", w), 32'(pc), 32'd0);
        end

        // HALT 0x38: halted rises on the 3rd cycle and stray acks are ignored.
        imem[0] = 8'h38;
        run = 1'b1;
        @(negedge clk);
        chk("halt_c2_halted", 32'(halted), 32'd0);
        @(negedge clk);
        chk("halt_c3_halted", 32'(halted), 32'd1);
        chk("halt_state", 32'(state), 32'd6);
        force_ack = 1'b1;
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            chk($sformatf("halt%0d_req", w), 32'(imem_req), 32'd0);
            chk($sformatf("halt%0d_state", w), 32'(state), 32'd6);
            chk($sformatf("halt%0d_pc", w), 32'(pc), 32'd1);
        end
        force_ack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
